// File: rtl/event_trig_capture.sv
// Event sequencer: arm on ev1, count trig strobes, wait a programmable delay, then
// capture breg into areg; abort cancels in flight. A retriggerable monostable drives q.
module event_trig_capture #(
   parameter int TRIG_COUNT  = 3,
   parameter int DELAY_W     = 8,
   parameter int DATA_W      = 8,
   parameter int HOLD_CYCLES = 250
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ev1,
   input  logic               trig,
   input  logic               abort,
   input  logic [DELAY_W-1:0] delay,
   input  logic [DATA_W-1:0]  breg,
   input  logic               retrig,
   output logic [DATA_W-1:0]  areg,
   output logic               areg_vld,
   output logic               aborted,
   output logic               busy,
   output logic               q,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DELAY = 2'd2
   } state_e;

   localparam int TCW = (TRIG_COUNT > 1) ? $clog2(TRIG_COUNT) : 1;
   localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [TCW-1:0] TRIG_LAST = TCW'(TRIG_COUNT - 1);
   localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

   state_e             state_q;
   logic [TCW-1:0]     tcnt_q;
   logic [DELAY_W-1:0] dcnt_q;
   logic [DATA_W-1:0]  areg_q;
   logic               areg_vld_q;
   logic               aborted_q;
   logic               busy_q;
   logic [HCW-1:0]     hcnt_q, hcnt_d;
   logic               q_q, q_d;

   // areg_vld is a one-cycle strobe with no ready: the consumer either takes areg
   // in that cycle or reads it later, since areg holds until the next capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         tcnt_q     <= '0;
         dcnt_q     <= '0;
         areg_q     <= '0;
         areg_vld_q <= 1'b0;
         aborted_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         areg_vld_q <= 1'b0;
         aborted_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (ev1 && !abort) begin
                  state_q <= ST_ARMED;
                  tcnt_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_ARMED: begin
               if (abort) begin
                  state_q   <= ST_IDLE;
                  aborted_q <= 1'b1;
                  busy_q    <= 1'b0;
               end else if (trig) begin
                  if (tcnt_q == TRIG_LAST) begin
                     state_q <= ST_DELAY;
                     tcnt_q  <= '0;
                     dcnt_q  <= delay;
                  end else begin
                     tcnt_q <= tcnt_q + TCW'(1);
                  end
               end
            end
            ST_DELAY: begin
               if (abort) begin
                  state_q   <= ST_IDLE;
                  aborted_q <= 1'b1;
                  busy_q    <= 1'b0;
               end else if (dcnt_q != '0) begin
                  dcnt_q <= dcnt_q - DELAY_W'(1);
               end else begin
                  areg_q     <= breg;
                  areg_vld_q <= 1'b1;
                  state_q    <= ST_IDLE;
                  busy_q     <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Monostable runs independently of the sequencer; a retrig always reloads.
   always_comb begin
      hcnt_d = hcnt_q;
      q_d    = q_q;
      if (retrig) begin
         q_d    = 1'b1;
         hcnt_d = HOLD_LOAD;
      end else if (q_q) begin
         if (hcnt_q != '0) hcnt_d = hcnt_q - HCW'(1);
         else              q_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt_q <= '0;
         q_q    <= 1'b0;
      end else begin
         hcnt_q <= hcnt_d;
         q_q    <= q_d;
      end
   end

   assign areg      = areg_q;
   assign areg_vld  = areg_vld_q;
   assign aborted   = aborted_q;
   assign busy      = busy_q;
   assign q         = q_q;
   assign dbg_state = state_q;

endmodule
